// File: rtl/math_div_seq.sv
// Signed iterative restoring divider: one quotient bit per enabled cycle,
// valid/ready on both sides, quotient truncated toward zero.
module math_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_num,
    input  logic [WIDTH-1:0] din_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout_quo,
    output logic [WIDTH-1:0] dout_rem,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             num_neg_q, num_neg_d;
    logic             den_neg_q, den_neg_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic [WIDTH:0]   den_abs_q, den_abs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dz_out_q, dz_out_d;
    logic             ovf_out_q, ovf_out_d;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;

    // rdy_q keeps in_ready low until the first enabled edge after reset release.
    assign in_ready  = ena & rdy_q & (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign dout_quo  = quo_out_q;
    assign dout_rem  = rem_out_q;
    assign div_zero  = dz_out_q;
    assign ovf       = ovf_out_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d     = state_q;
        rdy_d       = rdy_q;
        num_d       = num_q;
        den_d       = den_q;
        num_neg_d   = num_neg_q;
        den_neg_d   = den_neg_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        den_abs_d   = den_abs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        quo_out_d   = quo_out_q;
        rem_out_d   = rem_out_q;
        dz_out_d    = dz_out_q;
        ovf_out_d   = ovf_out_q;

        // Partial remainder stays below |den| <= 2^(WIDTH-1), so WIDTH+2 bits hold the trial sign.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, den_abs_q};
        q_signed = (num_neg_q ^ den_neg_q) ? -quo_q : quo_q;
        r_signed = num_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        if (ena) begin
            rdy_d = 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && rdy_q) begin
                        num_d   = din_num;
                        den_d   = din_den;
                        state_d = S_PREP;
                    end
                end
                S_PREP: begin
                    num_neg_d = num_q[WIDTH-1];
                    den_neg_d = den_q[WIDTH-1];
                    // Unsigned WIDTH-bit negation yields 2^(WIDTH-1) for the most-negative value.
                    quo_d     = num_q[WIDTH-1] ? -num_q : num_q;
                    den_abs_d = {1'b0, (den_q[WIDTH-1] ? -den_q : den_q)};
                    dz_d      = (den_q == '0);
                    ov_d      = (num_q == MOST_NEG) && (den_q == '1);
                    rem_d     = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = S_CALC;
                end
                S_CALC: begin
                    if (!diff[WIDTH+1]) begin
                        rem_d = diff[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (dz_q) begin
                        quo_out_d = num_neg_q ? MOST_NEG : MAX_POS;
                        rem_out_d = num_q;
                    end else if (ov_q) begin
                        quo_out_d = MAX_POS;
                        rem_out_d = '0;
                    end else begin
                        quo_out_d = q_signed;
                        rem_out_d = r_signed;
                    end
                    dz_out_d    = dz_q;
                    ovf_out_d   = ov_q && !dz_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            num_q       <= '0;
            den_q       <= '0;
            num_neg_q   <= 1'b0;
            den_neg_q   <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            den_abs_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            quo_out_q   <= '0;
            rem_out_q   <= '0;
            dz_out_q    <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            num_q       <= num_d;
            den_q       <= den_d;
            num_neg_q   <= num_neg_d;
            den_neg_q   <= den_neg_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            den_abs_q   <= den_abs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            quo_out_q   <= quo_out_d;
            rem_out_q   <= rem_out_d;
            dz_out_q    <= dz_out_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

endmodule

// File: tb/tb_math_div_seq.sv
// Bench for math_div_seq: directed vectors with literal expectations plus an
// arithmetic reference model checked by a negedge monitor on every valid cycle.
module tb_math_div_seq;

    localparam int W = 16;
    localparam logic [W-1:0] MAXP = 16'h7FFF;
    localparam logic [W-1:0] MINN = 16'h8000;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] din_num;
    logic [W-1:0] din_den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dout_quo;
    logic [W-1:0] dout_rem;
    logic         div_zero;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int en_cyc = 0;

    res_t exp_q[$];
    int   mark_q[$];
    logic prev_valid = 1'b0;

    math_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_num(din_num), .din_den(din_den),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_quo(dout_quo), .dout_rem(dout_rem),
        .div_zero(div_zero), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed integer division with the two special cases.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t res;
        int   sa, sb, t;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        res = '0;
        if (sb == 0) begin
            res.q  = (sa >= 0) ? MAXP : MINN;
            res.r  = a;
            res.dz = 1'b1;
        end else if (sa == -(1 << (W - 1)) && sb == -1) begin
            res.q  = MAXP;
            res.r  = '0;
            res.ov = 1'b1;
        end else begin
            t     = sa / sb;
            res.q = t[W-1:0];
            t     = sa % sb;
            res.r = t[W-1:0];
        end
        return res;
    endfunction

    always @(posedge clk) begin
        if (rst_n && ena) en_cyc <= en_cyc + 1;
    end

    // Monitor: every cycle with out_valid must match the oldest accepted operation.
    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            exp_q.delete();
            mark_q.delete();
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                check("mon_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    r = exp_q[0];
                    check("mon_quo", dout_quo, r.q);
                    check("mon_rem", dout_rem, r.r);
                    check("mon_div_zero", div_zero, r.dz);
                    check("mon_ovf", ovf, r.ov);
                    check("mon_in_ready_busy", in_ready, 0);
                    if (!prev_valid) check("mon_latency", en_cyc - mark_q[0], W + 3);
                    if (out_ready && ena) begin
                        void'(exp_q.pop_front());
                        void'(mark_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(din_num, din_den));
                mark_q.push_back(en_cyc);
            end
            prev_valid <= out_valid;
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 0;
        din_num  = a;
        din_den  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic wait_valid(output int n);
        bit got = 0;
        n = 0;
        while (n < 100 && !got) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else n++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eov, input bit stall);
        int  n = 0;
        bit  got = 0;
        do_op(a, b);
        while (n < 100 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (stall) ena = !(n >= 5 && n < 10);
            @(negedge clk);
            if (out_valid) got = 1;
        end
        check({name, "_latency"}, n, W + 2 + (stall ? 5 : 0));
        check({name, "_quo"}, dout_quo, eq);
        check({name, "_rem"}, dout_rem, er);
        check({name, "_div_zero"}, div_zero, edz);
        check({name, "_ovf"}, ovf, eov);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t m;
        int   n;
        logic [W-1:0] a, b;

        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din_num   = '0;
        din_den   = '0;

        // Pin the model against hand-computed values.
        m = model(16'd100, 16'd7);   check("model_100_7_q", m.q, 14);      check("model_100_7_r", m.r, 2);
        m = model(16'hFF9C, 16'd7);  check("model_m100_7_q", m.q, 16'hFFF2); check("model_m100_7_r", m.r, 16'hFFFE);
        m = model(16'h04D2, 16'd0);  check("model_dz_q", m.q, 16'h7FFF);   check("model_dz_flag", m.dz, 1);
        m = model(16'hFFFB, 16'd0);  check("model_dzneg_q", m.q, 16'h8000); check("model_dzneg_r", m.r, 16'hFFFB);
        m = model(16'h8000, 16'hFFFF); check("model_ovf_q", m.q, 16'h7FFF); check("model_ovf_flag", m.ov, 1);

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_quo", dout_quo, 0);
        check("rst_rem", dout_rem, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_ovf", ovf, 0);
        #20;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("rst_in_ready_after_edge", in_ready, 1);

        run_op("d100_7",    16'd100,  16'd7,    16'd14,   16'd2,    0, 0, 0);
        run_op("dm100_7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 0, 0, 0);
        run_op("d100_m7",   16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    0, 0, 0);
        run_op("dm100_m7",  16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 0, 0, 0);
        run_op("d1234_0",   16'h04D2, 16'd0,    16'h7FFF, 16'h04D2, 1, 0, 0);
        run_op("dm5_0",     16'hFFFB, 16'd0,    16'h8000, 16'hFFFB, 1, 0, 0);
        run_op("dmin_m1",   16'h8000, 16'hFFFF, 16'h7FFF, 16'd0,    0, 1, 0);
        run_op("dmin_1",    16'h8000, 16'd1,    16'h8000, 16'd0,    0, 0, 0);
        run_op("d7_100",    16'd7,    16'd100,  16'd0,    16'd7,    0, 0, 0);
        run_op("d0_m3",     16'd0,    16'hFFFD, 16'd0,    16'd0,    0, 0, 0);
        run_op("stall",     16'd1000, 16'd7,    16'd142,  16'd6,    0, 0, 1);

        // Backpressure, then ena low in DONE with out_ready high.
        out_ready = 1'b0;
        do_op(16'd300, 16'hFFF7);
        wait_valid(n);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid_hold", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_quo_hold", dout_quo, 16'hFFDF);
            check("bp_rem_hold", dout_rem, 16'd3);
        end
        ena       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("ena_low_no_transfer", out_valid, 1);
            check("ena_low_in_ready", in_ready, 0);
        end
        ena = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);

        // Back-to-back requests: accepts must be spaced W+4 cycles.
        begin
            int c = 0, first = -1, second = -1;
            din_num  = 16'd1000;
            din_den  = 16'd10;
            in_valid = 1'b1;
            while (second < 0 && c < 200) begin
                @(negedge clk);
                if (in_ready) begin
                    if (first < 0) first = c;
                    else second = c;
                end
                @(posedge clk);
                #1;
                c++;
            end
            in_valid = 1'b0;
            check("accept_spacing", second - first, W + 4);
        end
        repeat (25) @(posedge clk);
        #1;

        // Async reset mid-CALC: nothing may be emitted afterwards.
        do_op(16'd1000, 16'd3);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_calc_valid", out_valid, 0);
        check("arst_calc_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("arst_no_emit", out_valid, 0);

        // Async reset while holding a result in DONE.
        out_ready = 1'b0;
        do_op(16'd77, 16'd7);
        wait_valid(n);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_done_valid", out_valid, 0);
        check("arst_done_quo", dout_quo, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_op("d50_5", 16'd50, 16'd5, 16'd10, 16'd0, 0, 0, 0);

        // Random operands, biased toward the boundary values; monitor does the checking.
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = MINN; b = '1; end
                2: a = '0;
                3: b = W'($urandom_range(1, 5));
                4: a = MINN;
                default: ;
            endcase
            do_op(a, b);
        end
        repeat (30) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
